// File: rtl/perm_pkg.sv
// Shared constants, emit-FSM state type and chunk selector for the SHA3 permutation unload stage.
// Pure declarations; no timing or flow-control behaviour lives here.
package perm_pkg;
    localparam int STATE_W    = 1600;
    localparam int CHUNK_W    = 200;
    localparam int NUM_CHUNKS = 8;
    localparam int IX_W       = 3;
    localparam int LANE_W     = 64;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } emit_state_t;

    function automatic logic [CHUNK_W-1:0] chunk(input logic [STATE_W-1:0] st,
                                                 input logic [IX_W-1:0]    ix);
        return st[int'(ix)*CHUNK_W +: CHUNK_W];
    endfunction
endpackage

// File: rtl/perm_unload_if.sv
// State hand-off (valid/ready) and 200-bit chunk output bus of the permutation unload stage.
// master = round logic / consumer side, slave = perm_unload.
interface perm_unload_if;
    import perm_pkg::*;

    logic [STATE_W-1:0] state_in;
    logic               state_valid;
    logic               state_ready;
    logic [IX_W-1:0]    doutix;
    logic [CHUNK_W-1:0] dout;
    logic               pushout;
    logic               busy;

    modport master (
        output state_in, state_valid,
        input  state_ready, doutix, dout, pushout, busy
    );

    modport slave (
        input  state_in, state_valid,
        output state_ready, doutix, dout, pushout, busy
    );
endinterface

// File: rtl/perm_unload_buf.sv
// Two-slot FIFO of full 1600-bit states; head data is visible combinationally.
// Zero-latency push/pop; caller must not push when full or pop when empty.
module perm_unload_buf
    import perm_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_push,
    input  logic [STATE_W-1:0] i_push_dat,
    input  logic               i_pop,
    output logic [STATE_W-1:0] o_head_dat,
    output logic               o_not_empty,
    output logic               o_not_full
);
    logic [STATE_W-1:0] r_slot [2];
    logic               r_head;
    logic               r_tail;
    logic [1:0]         r_count;

    // Slot storage is not cleared on reset; a zero count already invalidates it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (i_push) begin
                r_slot[r_tail] <= i_push_dat;
                r_tail         <= ~r_tail;
            end
            if (i_pop) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_head_dat  = r_slot[r_head];
    assign o_not_empty = (r_count != 2'd0);
    assign o_not_full  = (r_count != 2'd2);
endmodule

// File: rtl/perm_unload.sv
// Streams each buffered 1600-bit state as 200-bit beats (8, or 2 with PERM_UNLOAD_DIGEST_ONLY_EN); first beat 1 cycle after accept.
// Upstream stalls via state_ready when both slots are full; downstream cannot stall.
module perm_unload
    import perm_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    perm_unload_if.slave  bus
);
`ifdef PERM_UNLOAD_DIGEST_ONLY_EN
    localparam logic [IX_W-1:0] LAST_BEAT = IX_W'(1);
`else
    localparam logic [IX_W-1:0] LAST_BEAT = IX_W'(NUM_CHUNKS - 1);
`endif

    emit_state_t        r_state;
    emit_state_t        w_state_nxt;
    logic [IX_W-1:0]    r_beat;
    logic [IX_W-1:0]    w_beat_nxt;
    logic               r_pushout;
    logic [IX_W-1:0]    r_doutix;
    logic [CHUNK_W-1:0] r_dout;
    logic               w_emit;
    logic               w_last;
    logic               w_pop;
    logic               w_push;
    logic               w_not_empty;
    logic               w_not_full;
    logic [STATE_W-1:0] w_head_dat;

    assign bus.state_ready = !reset && w_not_full;
    assign w_push          = bus.state_valid && bus.state_ready;

    perm_unload_buf u_buf (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_dat  (bus.state_in),
        .i_pop       (w_pop),
        .o_head_dat  (w_head_dat),
        .o_not_empty (w_not_empty),
        .o_not_full  (w_not_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_emit      = 1'b0;
        w_last      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_not_empty) begin
                    w_emit      = 1'b1;
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (w_not_empty) w_emit = 1'b1;
                else             w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_emit) begin
            w_last     = (r_beat == LAST_BEAT);
            w_pop      = w_last;
            w_beat_nxt = w_last ? '0 : r_beat + IX_W'(1);
            // Freeing the only slot with nothing arriving empties the buffer.
            if (w_last && !w_push && w_not_full) w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pushout <= 1'b0;
            r_doutix  <= '0;
            r_dout    <= '0;
        end else begin
            r_pushout <= w_emit;
            if (w_emit) begin
                r_doutix <= r_beat;
                r_dout   <= chunk(w_head_dat, r_beat);
            end
        end
    end

    assign bus.pushout = r_pushout;
    assign bus.doutix  = r_doutix;
    assign bus.dout    = r_dout;
    assign bus.busy    = w_not_empty || r_pushout;
endmodule

// File: tb/tb_perm_unload.sv
// Bench for perm_unload: queue-of-states reference model checked every cycle plus directed scenarios.
module tb_perm_unload;
    import perm_pkg::*;

`ifdef PERM_UNLOAD_DIGEST_ONLY_EN
    localparam int N = 2;
`else
    localparam int N = NUM_CHUNKS;
`endif

    typedef struct {
        int                 cyc;
        logic [IX_W-1:0]    ix;
        logic [CHUNK_W-1:0] d;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    perm_unload_if bus();
    perm_unload dut (.clk(clk), .reset(rst), .bus(bus.slave));

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [CHUNK_W-1:0] obs, input logic [CHUNK_W-1:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: FIFO of whole states; while non-empty, one beat per cycle from the front.
    logic [STATE_W-1:0] mq[$];
    int                 mbeat;
    logic               e_push;
    logic [IX_W-1:0]    e_ix;
    logic [CHUNK_W-1:0] e_dout;
    bit                 chk_en = 1'b0;
    beat_t              log_q[$];

    always @(posedge clk) begin
        logic               acc;
        logic [STATE_W-1:0] hd;
        if (rst) begin
            mq.delete();
            mbeat  = 0;
            e_push = 1'b0;
            e_ix   = '0;
            e_dout = '0;
        end else begin
            acc = bus.state_valid && (mq.size() < 2);
            if (mq.size() > 0) begin
                hd     = mq[0];
                e_push = 1'b1;
                e_ix   = IX_W'(mbeat);
                e_dout = hd[mbeat*CHUNK_W +: CHUNK_W];
                mbeat++;
                if (mbeat == N) begin
                    void'(mq.pop_front());
                    mbeat = 0;
                end
            end else begin
                e_push = 1'b0;
            end
            if (acc) mq.push_back(bus.state_in);
        end
    end

    always @(negedge clk) begin
        if (bus.pushout === 1'b1) log_q.push_back('{cyc, bus.doutix, bus.dout});
        if (chk_en) begin
            chk("ready",   bus.state_ready, !rst && (mq.size() < 2));
            chk("pushout", bus.pushout, e_push);
            chk("busy",    bus.busy, (mq.size() > 0) || e_push);
            if (e_push) begin
                chk("doutix", bus.doutix, e_ix);
                chk("dout",   bus.dout, e_dout);
            end
        end
    end

    // Present a state from a negedge; returns at the negedge after the accepting edge.
    task automatic offer(input logic [STATE_W-1:0] s, output int acc_cyc);
        int n = 0;
        bus.state_in    = s;
        bus.state_valid = 1'b1;
        acc_cyc = -1;
        while (bus.state_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("offer_timeout", bus.state_ready, 1);
            bus.state_valid = 1'b0;
        end else begin
            @(negedge clk);
            acc_cyc = cyc;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        bus.state_valid = 1'b0;
        while (bus.busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("idle_timeout", bus.busy, 0);
        @(negedge clk);
    endtask

    function automatic logic [STATE_W-1:0] fill(input logic [7:0] b);
        return {200{b}};
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [STATE_W-1:0] s;
        logic [CHUNK_W-1:0] d0;
        int ac_a, ac_b, ac_c, gap;

        rst             = 1'b1;
        bus.state_valid = 1'b0;
        bus.state_in    = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pushout", bus.pushout, 0);
        chk("rst_doutix",  bus.doutix, 0);
        chk("rst_dout",    bus.dout, 0);
        chk("rst_busy",    bus.busy, 0);
        chk("rst_ready",   bus.state_ready, 0);
        chk_en = 1'b1;
        rst    = 1'b0;
        @(negedge clk);

        // Single state with a distinct byte per chunk
        for (int i = 0; i < NUM_CHUNKS; i++) s[i*CHUNK_W +: CHUNK_W] = {25{8'(i+1)}};
        log_q.delete();
        offer(s, ac_a);
        wait_idle();
        chk("t1_nbeats", log_q.size(), N);
        for (int i = 0; i < N && i < log_q.size(); i++) begin
            chk("t1_ix",   log_q[i].ix, i);
            chk("t1_dout", log_q[i].d, {25{8'(i+1)}});
            chk("t1_cyc",  log_q[i].cyc, ac_a + 1 + i);
        end
        chk("t1_busy",    bus.busy, 0);
        chk("t1_pushout", bus.pushout, 0);

        // Back-to-back A, B
        log_q.delete();
        offer(fill(8'hAA), ac_a);
        offer(fill(8'h55), ac_b);
        wait_idle();
        chk("t2_acc_b", ac_b, ac_a + 1);
        chk("t2_nbeats", log_q.size(), 2*N);
        for (int i = 0; i < 2*N && i < log_q.size(); i++) begin
            chk("t2_cyc",  log_q[i].cyc, log_q[0].cyc + i);
            chk("t2_dout", log_q[i].d, (i < N) ? {25{8'hAA}} : {25{8'h55}});
        end

        // Full buffer: C must wait while both slots are occupied
        log_q.delete();
        offer(fill(8'hA1), ac_a);
        offer(fill(8'hB2), ac_b);
        chk("t3_ready_full", bus.state_ready, 0);
        offer(fill(8'hC3), ac_c);
        wait_idle();
        chk("t3_nbeats", log_q.size(), 3*N);
        for (int i = 0; i < 3*N && i < log_q.size(); i++) begin
            chk("t3_cyc",  log_q[i].cyc, log_q[0].cyc + i);
            chk("t3_dout", log_q[i].d, (i < N) ? {25{8'hA1}} : (i < 2*N) ? {25{8'hB2}} : {25{8'hC3}});
        end

        // Reset in the middle of A with B buffered
        offer(fill(8'h11), ac_a);
        offer(fill(8'h22), ac_b);
        bus.state_valid = 1'b0;
        repeat ((N > 2) ? 2 : 0) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        log_q.delete();
        chk("t4_pushout_rst", bus.pushout, 0);
        chk("t4_ready_rst",   bus.state_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("t4_ready_after", bus.state_ready, 1);
        repeat (20) @(negedge clk);
        chk("t4_no_beats", log_q.size(), 0);
        chk("t4_busy",     bus.busy, 0);

        // Lane (x=1,y=0) lands in bits 127:64 of beat 0
        s = '0;
        s[LANE_W*(5*0+1) +: LANE_W] = 64'h0123456789ABCDEF;
        log_q.delete();
        offer(s, ac_a);
        wait_idle();
        chk("t5_nbeats", log_q.size(), N);
        if (log_q.size() > 0) begin
            d0 = log_q[0].d;
            chk("t5_lane", d0[127:64], 64'h0123456789ABCDEF);
            d0[127:64] = '0;
            chk("t5_rest0", d0, 0);
        end
        for (int i = 1; i < N && i < log_q.size(); i++) chk("t5_zero", log_q[i].d, 0);

        // Random traffic with random gaps, checked cycle by cycle against the model
        log_q.delete();
        for (int k = 0; k < 40; k++) begin
            gap = $urandom_range(0, 12);
            if (gap > 6) gap = 0;
            bus.state_valid = 1'b0;
            repeat (gap) @(negedge clk);
            for (int j = 0; j < STATE_W/32; j++) s[j*32 +: 32] = $urandom;
            offer(s, ac_a);
        end
        wait_idle();
        chk("t6_nbeats", log_q.size(), 40*N);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
